ctrl_code_pipe_stage: RTL

Parametrised second-stage control-code generator for the pipelined RISC datapath.
- Decodes a registered opcode into a control word through a run-time-loadable decode table.
- Inserts bubbles on hold, flush, or a table-specified post-issue bubble count.
- Delays the forwarded control bits from stage 1 so they stay aligned with the control word.
- Replaces a hardwired casex decoder. The table gives the same 1-cycle latency and adds stall/flush handling and multi-cycle bubble insertion.

---
 rtl/ctrl_code_pipe_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/ctrl_code_pipe_stage.sv
// Second-stage control-code generator: table-driven opcode decode with
// hold/flush/stall handling and per-opcode post-issue bubble insertion.
module ctrl_code_pipe_stage #(
  parameter int unsigned OPW   = 8,
  parameter int unsigned CW    = 10,
  parameter int unsigned FWD_W = 3,
  parameter int unsigned HCW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [OPW-1:0]     opcode,
  input  logic               hold,
  input  logic               flush,
  input  logic               stall_in,
  input  logic [FWD_W-1:0]   fwd_in,
  input  logic               tbl_we,
  input  logic [OPW-1:0]     tbl_addr,
  input  logic [CW+HCW-1:0]  tbl_data,
  output logic [CW-1:0]      ctrl_out,
  output logic [FWD_W-1:0]   fwd_out,
  output logic [OPW-1:0]     opcode_out,
  output logic               out_valid,
  output logic               hold_req
);

  localparam int unsigned EW      = CW + HCW;
  localparam int unsigned ENTRIES = 2 ** OPW;

  logic [EW-1:0]    tbl_q [ENTRIES];
  logic [EW-1:0]    entry_c;
  logic             issue_c;
  logic             bcnt_busy_c;

  logic [CW-1:0]    ctrl_q,  ctrl_d;
  logic [FWD_W-1:0] fwd_q,   fwd_d;
  logic [OPW-1:0]   opc_q,   opc_d;
  logic             vld_q,   vld_d;
  logic [HCW-1:0]   bcnt_q,  bcnt_d;

  // Decode table storage; entry 0 is never written so it reads as a fixed NOP.
  always_ff @(posedge clk) begin
    if (tbl_we && (tbl_addr != '0)) begin
      tbl_q[tbl_addr] <= tbl_data;
    end
  end

  // Table lookup (old contents on a same-cycle write) and issue qualification.
  always_comb begin
    entry_c     = (opcode == '0) ? '0 : tbl_q[opcode];
    bcnt_busy_c = (bcnt_q != '0);
    issue_c     = in_valid & ~hold & ~flush & ~stall_in & ~bcnt_busy_c;
  end

  // Next-state selection, first matching condition wins.
  always_comb begin
    ctrl_d = '0;
    fwd_d  = '0;
    opc_d  = '0;
    vld_d  = 1'b0;
    bcnt_d = '0;
    if (flush) begin
      bcnt_d = '0;
    end else if (stall_in) begin
      ctrl_d = ctrl_q;
      fwd_d  = fwd_q;
      opc_d  = opc_q;
      vld_d  = vld_q;
      bcnt_d = bcnt_q;
    end else if (bcnt_busy_c) begin
      bcnt_d = bcnt_q - HCW'(1);
    end else if (issue_c) begin
      ctrl_d = entry_c[CW-1:0];
      fwd_d  = fwd_in;
      opc_d  = opcode;
      vld_d  = 1'b1;
      bcnt_d = entry_c[EW-1:CW];
    end
  end

  // Output and bubble-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      fwd_q  <= '0;
      opc_q  <= '0;
      vld_q  <= 1'b0;
      bcnt_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      fwd_q  <= fwd_d;
      opc_q  <= opc_d;
      vld_q  <= vld_d;
      bcnt_q <= bcnt_d;
    end
  end

  // Upstream must keep its opcode while frozen or while bubbles drain.
  always_comb begin
    hold_req = stall_in | bcnt_busy_c;
  end

  assign ctrl_out   = ctrl_q;
  assign fwd_out    = fwd_q;
  assign opcode_out = opc_q;
  assign out_valid  = vld_q;

endmodule
